stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter IF_LAT, default 1, instruction-fetch wait cycles spent in IF_WAIT; legal 1..15.
REQ-002 Parameter MEM_LAT, default 1, data-memory wait cycles spent in MEM_WAIT; legal 1..15.
REQ-003 Parameter USE_READY, default 0, 1 = wait states also require the memory ready inputs.
REQ-004 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-005 Port clk  input  1  clock; all state changes on the rising edge.
REQ-006 Port reset_n  input  1  reset, synchronous, active-low.
REQ-007 Port stall  input  1  freezes the sequencer in its current cycle.
REQ-008 Port halt_req  input  1  stop after the current instruction retires.
REQ-009 Port imem_ready  input  1  fetch data valid; ignored when USE_READY=0.
REQ-010 Port dmem_ready  input  1  load data valid; ignored when USE_READY=0.
REQ-011 Ports pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren, ram_wren, reg_wren  output  1 each  write enables.
REQ-012 Port stage_reset_n  output  1  active-low clear for the inter-stage registers.
REQ-013 Port stage  output  4  current state encoding.
REQ-014 Port halted  output  1  high while in HALT.
REQ-015 Port instret  output  CNT_W  count of retired instructions.

Function
REQ-016 States and encodings SHALL be INIT=0, IF=1, IF_WAIT=2, ID=3, EX=4, MEM=5, MEM_WAIT=6, WB=7, HALT=8.
REQ-017 Transitions SHALL be INIT->IF->IF_WAIT->ID->EX->MEM->MEM_WAIT->WB->IF, one per unstalled cycle, except the wait states (REQ-018, REQ-019) and WB with halt_req=1, which goes to HALT.
REQ-018 IF_WAIT SHALL last exactly IF_LAT unstalled cycles, or, with USE_READY=1, until the count has expired and imem_ready=1.
REQ-019 MEM_WAIT SHALL last exactly MEM_LAT unstalled cycles, or, with USE_READY=1, until the count has expired and dmem_ready=1.
REQ-020 The wait counter SHALL load on entry to each wait state and SHALL not decrement below zero.
REQ-021 Outputs SHALL be decoded combinationally from the registered state (Moore).
REQ-022 Per-state outputs SHALL be as follows; all enables not listed are 0:
 - INIT: stage_reset_n=0.
 - IF: stage_reset_n=1.
 - IF_WAIT: if_id_wren=1 on the exit cycle only.
 - ID: id_ex_wren=1.
 - EX: ex_mem_wren=1.
 - MEM: pc_wren=1, ram_wren=1.
 - MEM_WAIT: mem_wb_wren=1 on the exit cycle only.
 - WB: reg_wren=1, stage_reset_n=0.
 - HALT: all enables 0, stage_reset_n=0, halted=1.
 - stage_reset_n SHALL be 1 in every state not listed above with it set to 0.
REQ-023 While stall=1 the state, wait counter and instret SHALL hold, and all seven write enables SHALL be forced to 0.
REQ-024 stage_reset_n SHALL follow the state decode regardless of stall.
REQ-025 instret SHALL increment by 1 on each unstalled WB cycle and SHALL wrap from all-ones to 0.
REQ-026 halt_req SHALL be sampled only in an unstalled WB cycle; in every other state it has no effect.
REQ-027 HALT SHALL be exited only by reset.
REQ-028 Each enable SHALL be high for at most one cycle per instruction, except under stall, where it is dropped (REQ-023).

Reset
REQ-029 When reset_n=0 at a clock edge: state SHALL become INIT, the wait counter 0, and instret 0, from any state including mid-wait and HALT.
REQ-030 While in INIT after reset, all enables SHALL be 0, stage_reset_n=0, halted=0 and stage=0.
REQ-031 Reset SHALL take priority over stall and halt_req.
REQ-032 The first fetch (IF) SHALL occur on the second clock edge after reset_n rises.

Verification
REQ-033 IF_LAT=1, MEM_LAT=1, USE_READY=0, free run -> stage sequence 0,1,2,3,4,5,6,7,1; instret=3 after 3 WB cycles; each enable pulses once per 7-cycle instruction.
REQ-034 IF_LAT=3, MEM_LAT=2 -> IF_WAIT held 3 cycles with if_id_wren only on the 3rd; MEM_WAIT held 2 cycles with mem_wb_wren only on the 2nd; instruction period 10 cycles.
REQ-035 USE_READY=1, dmem_ready low for 5 cycles in MEM_WAIT -> stage stays 6 for 5 extra cycles; mem_wb_wren rises only in the cycle where dmem_ready=1.
REQ-036 stall=1 for 4 cycles during MEM -> stage holds at 5; pc_wren=ram_wren=0 throughout; after release exactly one pc_wren/ram_wren pulse; instret unchanged during the stall.
REQ-037 halt_req=1 during WB -> stage=8, halted=1 and instret incremented once; then reset_n=0 for 1 cycle -> stage=0, instret=0.
REQ-038 CNT_W=4, 16 retirements -> instret wraps 15->0; reset asserted mid-IF_WAIT -> INIT next cycle, with no if_id_wren pulse.

Source files
------------

// File: rtl/stage_sequencer.sv
// Multi-cycle pipeline stage sequencer. A Moore FSM steps one instruction through
// IF..WB, with wait states that count down a latency and can optionally also wait on memory ready.
module stage_sequencer #(
  parameter int IF_LAT    = 1,
  parameter int MEM_LAT   = 1,
  parameter bit USE_READY = 1'b0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_wren,
  output logic             if_id_wren,
  output logic             id_ex_wren,
  output logic             ex_mem_wren,
  output logic             mem_wb_wren,
  output logic             ram_wren,
  output logic             reg_wren,
  output logic             stage_reset_n,
  output logic [3:0]       stage,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_INIT = 4'd0, S_IF = 4'd1, S_IF_WAIT = 4'd2, S_ID = 4'd3, S_EX = 4'd4,
    S_MEM = 4'd5, S_MEM_WAIT = 4'd6, S_WB = 4'd7, S_HALT = 4'd8
  } state_t;

  // The counter holds the number of wait cycles still owed after the current one.
  localparam logic [3:0] IF_LD  = 4'(IF_LAT - 1);
  localparam logic [3:0] MEM_LD = 4'(MEM_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             if_done, mem_done;

  assign if_done  = (state_q == S_IF_WAIT)  && (cnt_q == 4'd0) && (!USE_READY || imem_ready);
  assign mem_done = (state_q == S_MEM_WAIT) && (cnt_q == 4'd0) && (!USE_READY || dmem_ready);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instret_d = instret_q;
    if (!stall) begin
      unique case (state_q)
        S_INIT:     state_d = S_IF;
        S_IF:       begin state_d = S_IF_WAIT; cnt_d = IF_LD; end
        S_IF_WAIT:  if (if_done) state_d = S_ID;
                    else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        S_ID:       state_d = S_EX;
        S_EX:       state_d = S_MEM;
        S_MEM:      begin state_d = S_MEM_WAIT; cnt_d = MEM_LD; end
        S_MEM_WAIT: if (mem_done) state_d = S_WB;
                    else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        S_WB:       begin
                      instret_d = instret_q + CNT_W'(1);
                      state_d   = halt_req ? S_HALT : S_IF;
                    end
        S_HALT:     state_d = S_HALT;
        default:    state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      cnt_q     <= 4'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
    end
  end

  // Enables are dropped under stall; stage_reset_n ignores stall.
  assign pc_wren       = !stall && (state_q == S_MEM);
  assign ram_wren      = !stall && (state_q == S_MEM);
  assign if_id_wren    = !stall && if_done;
  assign id_ex_wren    = !stall && (state_q == S_ID);
  assign ex_mem_wren   = !stall && (state_q == S_EX);
  assign mem_wb_wren   = !stall && mem_done;
  assign reg_wren      = !stall && (state_q == S_WB);
  assign stage_reset_n = !(state_q inside {S_INIT, S_WB, S_HALT});
  assign halted        = (state_q == S_HALT);
  assign stage         = state_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench: two sequencer configurations driven by shared random inputs,
// each compared every cycle against an instruction-level reference model.
module tb_stage_sequencer;
  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic reset_n, stall, halt_req, imem_ready, dmem_ready;
  logic [6:0]  en   [2];
  logic        srn  [2];
  logic        hlt  [2];
  logic [3:0]  stg  [2];
  logic [31:0] ir0;
  logic [3:0]  ir1;

  stage_sequencer u_a (
    .clk(gclk), .reset_n(reset_n), .stall(stall), .halt_req(halt_req),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_wren(en[0][6]), .if_id_wren(en[0][5]), .id_ex_wren(en[0][4]), .ex_mem_wren(en[0][3]),
    .mem_wb_wren(en[0][2]), .ram_wren(en[0][1]), .reg_wren(en[0][0]),
    .stage_reset_n(srn[0]), .stage(stg[0]), .halted(hlt[0]), .instret(ir0));

  stage_sequencer #(.IF_LAT(3), .MEM_LAT(2), .USE_READY(1'b1), .CNT_W(4)) u_b (
    .clk(gclk), .reset_n(reset_n), .stall(stall), .halt_req(halt_req),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_wren(en[1][6]), .if_id_wren(en[1][5]), .id_ex_wren(en[1][4]), .ex_mem_wren(en[1][3]),
    .mem_wb_wren(en[1][2]), .ram_wren(en[1][1]), .reg_wren(en[1][0]),
    .stage_reset_n(srn[1]), .stage(stg[1]), .halted(hlt[1]), .instret(ir1));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model: stage name plus cycles of wait remaining (including the current one).
  int          lat_if [2] = '{1, 3};
  int          lat_mem[2] = '{1, 2};
  bit          use_rdy[2] = '{0, 1};
  int unsigned mask   [2] = '{32'hFFFF_FFFF, 32'hF};
  int          m_st[2], m_rem[2];
  int unsigned m_cnt[2];
  int          wraps = 0;

  function automatic bit wait_over(int k, bit rdy);
    return (m_rem[k] <= 1) && (!use_rdy[k] || rdy);
  endfunction

  task automatic check_outputs(int k);
    logic [6:0] e;
    e = 7'b0;
    case (m_st[k])
      2: e[5] = wait_over(k, imem_ready);
      3: e[4] = 1'b1;
      4: e[3] = 1'b1;
      5: begin e[6] = 1'b1; e[1] = 1'b1; end
      6: e[2] = wait_over(k, dmem_ready);
      7: e[0] = 1'b1;
      default: ;
    endcase
    if (stall) e = 7'b0;
    chk($sformatf("stage%0d", k), 32'(stg[k]), 32'(m_st[k]));
    chk($sformatf("en%0d", k), 32'(en[k]), 32'(e));
    chk($sformatf("srn%0d", k), 32'(srn[k]), 32'(!(m_st[k] inside {0, 7, 8})));
    chk($sformatf("halted%0d", k), 32'(hlt[k]), 32'(m_st[k] == 8));
    chk($sformatf("instret%0d", k), (k == 0) ? ir0 : 32'(ir1), m_cnt[k]);
  endtask

  task automatic step_model(int k);
    if (!reset_n) begin
      m_st[k] = 0; m_rem[k] = 0; m_cnt[k] = 0;
    end else if (!stall) begin
      case (m_st[k])
        1: begin m_st[k] = 2; m_rem[k] = lat_if[k]; end
        2: if (wait_over(k, imem_ready)) m_st[k] = 3; else if (m_rem[k] > 1) m_rem[k]--;
        5: begin m_st[k] = 6; m_rem[k] = lat_mem[k]; end
        6: if (wait_over(k, dmem_ready)) m_st[k] = 7; else if (m_rem[k] > 1) m_rem[k]--;
        7: begin
             m_cnt[k] = (m_cnt[k] + 1) & mask[k];
             if (k == 1 && m_cnt[k] == 0) wraps++;
             m_st[k] = halt_req ? 8 : 1;
           end
        8: ;
        default: m_st[k]++;
      endcase
    end
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; halt_req = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin m_st[k] = 0; m_rem[k] = 0; m_cnt[k] = 0; end
    for (int c = 0; c < 6000; c++) begin
      @(negedge gclk);
      if (c < 2)        reset_n = 1'b0;
      else              reset_n = ($urandom_range(0, 299) != 0);
      stall      = ($urandom_range(0, 5) == 0);
      halt_req   = ($urandom_range(0, 39) == 0);
      imem_ready = ($urandom_range(0, 2) != 0);
      dmem_ready = ($urandom_range(0, 2) != 0);
      #1;
      for (int k = 0; k < 2; k++) check_outputs(k);
      @(posedge gclk);
      for (int k = 0; k < 2; k++) step_model(k);
    end
    // Make sure a 4-bit wrap actually occurred in the run.
    chk("wrap_seen", 32'(wraps > 0), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
